// File: rtl/blink_pkg.sv
// Shared types and constants for the LED blink controller.
// State encoding, register map and CTRL bit positions.
package blink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_e;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_ON_MS  = 2'd1;
  localparam logic [1:0] A_OFF_MS = 2'd2;
  localparam logic [1:0] A_COUNT  = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_CLR   = 2;

  localparam int RST_MS = 500;

endpackage

// File: rtl/blink_ctrl.sv
// Register-programmed LED blinker driving an external ms timer.
// Define BLINK_CTRL_IRQ_EN to add the done_irq output.
module blink_ctrl
  import blink_pkg::*;
#(
  parameter int MS_W  = 16,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [1:0]      wr_addr,
  input  logic [MS_W-1:0] wr_data,
  input  logic [1:0]      rd_addr,
  output logic [MS_W-1:0] rd_data,
  input  logic [MS_W-1:0] tmr_ms,
  output logic            tmr_en,
  output logic            tmr_clr,
  output logic            led,
  output logic            busy
`ifdef BLINK_CTRL_IRQ_EN
  ,
  output logic            done_irq
`endif
);

  state_e state_q, state_d;

  logic [MS_W-1:0]  on_ms_q, off_ms_q;
  logic [CNT_W-1:0] count_q;

  logic [MS_W-1:0]  on_sh_q, on_sh_d;
  logic [MS_W-1:0]  off_sh_q, off_sh_d;
  logic [MS_W-1:0]  on_eff, off_eff;
  logic [CNT_W-1:0] rem_q, rem_d;

  logic clr_q, clr_d;
  logic settle_q;
  logic done_q, done_d;
  logic done_evt;

  logic ctrl_wr, start, stop, clr_done;
  logic tmr_ok;

  assign ctrl_wr  = wr_en && (wr_addr == A_CTRL);
  assign start    = ctrl_wr && wr_data[CTRL_START];
  assign stop     = ctrl_wr && wr_data[CTRL_STOP];
  assign clr_done = ctrl_wr && wr_data[CTRL_CLR];

  // timer value is stale while clearing and one cycle after
  assign tmr_ok = !clr_q && !settle_q;

  assign on_eff  = (on_sh_q == '0) ? MS_W'(1) : on_sh_q;
  assign off_eff = (off_sh_q == '0) ? MS_W'(1) : off_sh_q;

  assign tmr_clr = clr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      on_ms_q  <= MS_W'(RST_MS);
      off_ms_q <= MS_W'(RST_MS);
      count_q  <= '0;
    end else if (wr_en) begin
      unique case (wr_addr)
        A_ON_MS:  on_ms_q  <= wr_data;
        A_OFF_MS: off_ms_q <= wr_data;
        A_COUNT:  count_q  <= wr_data[CNT_W-1:0];
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      on_sh_q  <= '0;
      off_sh_q <= '0;
      clr_q    <= 1'b0;
      settle_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      on_sh_q  <= on_sh_d;
      off_sh_q <= off_sh_d;
      clr_q    <= clr_d;
      settle_q <= clr_q;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    on_sh_d  = on_sh_q;
    off_sh_d = off_sh_q;
    clr_d    = 1'b0;
    done_d   = done_q;
    done_evt = 1'b0;
    if (clr_done) begin
      done_d = 1'b0;
    end
    if (stop) begin
      state_d = ST_IDLE;
    end else if (start) begin
      on_sh_d  = on_ms_q;
      off_sh_d = off_ms_q;
      rem_d    = count_q;
      clr_d    = 1'b1;
      done_d   = 1'b0;
      state_d  = ST_ON;
    end else begin
      unique case (state_q)
        ST_ON: begin
          if (tmr_ok && (tmr_ms >= on_eff)) begin
            clr_d   = 1'b1;
            state_d = ST_OFF;
          end
        end
        ST_OFF: begin
          if (tmr_ok && (tmr_ms >= off_eff)) begin
            if (rem_q == CNT_W'(1)) begin
              state_d  = ST_IDLE;
              done_d   = 1'b1;
              done_evt = 1'b1;
            end else begin
              // zero means endless blinking
              if (rem_q != '0) begin
                rem_d = rem_q - CNT_W'(1);
              end
              on_sh_d  = on_ms_q;
              off_sh_d = off_ms_q;
              clr_d    = 1'b1;
              state_d  = ST_ON;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    led    = 1'b0;
    tmr_en = 1'b0;
    busy   = 1'b0;
    unique case (state_q)
      ST_ON: begin
        led    = 1'b1;
        tmr_en = 1'b1;
        busy   = 1'b1;
      end
      ST_OFF: begin
        tmr_en = 1'b1;
        busy   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_data = '0;
    unique case (rd_addr)
      A_CTRL:   rd_data = MS_W'({done_q, busy, state_q});
      A_ON_MS:  rd_data = on_ms_q;
      A_OFF_MS: rd_data = off_ms_q;
      A_COUNT:  rd_data = MS_W'(count_q);
      default:  ;
    endcase
  end

`ifdef BLINK_CTRL_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= done_evt;
    end
  end

  assign done_irq = irq_q;
`else
  logic unused_evt;
  assign unused_evt = done_evt;
`endif

endmodule

// File: doc/blink_ctrl.md
BLINK_CTRL -- requirements
Module: blink_ctrl

Interface
REQ-001 SHALL have parameter MS_W, default 16, width of the millisecond count and duration registers.
REQ-002 SHALL have parameter CNT_W, default 8, width of the blink-count register.
REQ-003 SHALL have port clk  input  1  single system clock; all state rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port wr_en  input  1  register write strobe, one write per cycle.
REQ-006 SHALL have port wr_addr  input  2  write address: 0 CTRL, 1 ON_MS, 2 OFF_MS, 3 COUNT.
REQ-007 SHALL have port wr_data  input  MS_W  write data.
REQ-008 SHALL have port rd_addr  input  2  read address, same map.
REQ-009 SHALL have port rd_data  output  MS_W  combinational read data.
REQ-010 SHALL have port tmr_ms  input  MS_W  elapsed-ms count from the external ms timer.
REQ-011 SHALL have port tmr_en  output  1  timer count enable.
REQ-012 SHALL have port tmr_clr  output  1  one-cycle timer clear pulse, active-high.
REQ-013 SHALL have port led  output  1  LED drive, 1 = lit.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, ON, OFF.
REQ-016 SHALL treat CTRL write bit0=start, bit1=stop, bit2=clear done; stop SHALL win over a simultaneous start.
REQ-017 SHALL on start (any state): latch ON_MS/OFF_MS into phase shadows, load remaining = COUNT, pulse tmr_clr, enter ON, clear done.
REQ-018 SHALL drive led=1 in ON, led=0 in IDLE and OFF; tmr_en=1 in ON and OFF only.
REQ-019 SHALL ignore tmr_ms in the cycle immediately after any tmr_clr pulse (timer settle).
REQ-020 SHALL end ON when tmr_ms >= on shadow: pulse tmr_clr, enter OFF.
REQ-021 SHALL end OFF when tmr_ms >= off shadow: if remaining==1 enter IDLE and set done; else decrement remaining (if nonzero), re-latch shadows, pulse tmr_clr, enter ON.
REQ-022 SHALL treat COUNT==0 as blink forever (remaining never decremented).
REQ-023 SHALL treat a shadow duration of 0 as 1 ms.
REQ-024 SHALL apply ON_MS/OFF_MS writes made while busy only at the next ON entry (shadow re-latch).
REQ-025 SHALL on stop: enter IDLE next cycle, led=0, tmr_en=0, done unchanged.
REQ-026 SHALL return on read addr0 {zero-pad, done, busy, state[1:0]}, addr1/2/3 the written register values (upper bits of COUNT zero).

Reset
REQ-027 SHALL on rst low asynchronously force state=IDLE, led=0, tmr_en=0, tmr_clr=0, done=0, ON_MS=500, OFF_MS=500, COUNT=0, remaining=0.
REQ-028 SHALL ignore all writes while rst is low; first write accepted on the first clk edge after release.

Configuration
REQ-029 SHALL, when BLINK_CTRL_IRQ_EN is defined, add output done_irq (1 bit) pulsing high one cycle on the IDLE entry of REQ-021.
REQ-030 SHALL, without BLINK_CTRL_IRQ_EN, have no done_irq port; done remains readable via CTRL.

Structure
REQ-031 SHALL place the state enum, register address constants and CTRL bit positions in shared package blink_pkg.
REQ-032 SHALL contain no sub-module; the ms timer stays external, connected via tmr_en/tmr_clr/tmr_ms.

Verification
REQ-033 Reset mid-ON (led=1) -> led=0, busy=0, rd addr1=500 immediately, without a clk edge.
REQ-034 ON_MS=3, OFF_MS=2, COUNT=2, start, timer model incrementing each cycle -> led pattern 1,1,1,0,0,1,1,1,0,0 (plus clr/settle cycles), then IDLE, done=1, one done_irq pulse with macro.
REQ-035 COUNT=0, start, run 5 periods, write CTRL=3 (start+stop) -> IDLE next cycle, led=0, done=0.
REQ-036 ON_MS=0, start -> ON lasts exactly as for ON_MS=1.
REQ-037 While in OFF write ON_MS=10 -> current period unchanged, next ON uses 10.
REQ-038 Start while busy in OFF with remaining=1 -> tmr_clr pulse, ON entered, remaining reloaded from COUNT, no done.
